// File: rtl/zap_wb_mem_responder.sv
// Wishbone B3 classic responder over a word-addressed RAM.
// Programmable wait states; out-of-range accesses end in err.
module zap_wb_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [3:0]  r_sel;
    logic        r_wen;

    logic        w_cap;
    logic        w_ack_nxt;
    logic        w_err_nxt;
    logic        w_busy_nxt;
    logic [31:0] w_dat_nxt;
    logic [31:0] w_off;
    logic        w_in_range;
    logic [AW-1:0] w_idx;
    logic        w_do_write;

    logic [31:0] mem [DEPTH];

    // Unsigned 32-bit offset; addresses below base wrap and are rejected.
    assign w_off      = r_adr - BASE_ADDR;
    assign w_in_range = (r_adr >= BASE_ADDR) && ((w_off >> 2) < 32'(DEPTH));
    assign w_idx      = w_off[AW+1:2];
    assign w_do_write = (r_state == S_RESP) && w_in_range && r_wen && !i_reset;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cap       = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_nxt   = 32'h0;
        unique case (r_state)
            S_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    w_cap       = 1'b1;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                    w_state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (w_in_range) begin
                    w_ack_nxt = 1'b1;
                    w_dat_nxt = r_wen ? 32'h0 : mem[w_idx];
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE) || w_ack_nxt || w_err_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'h0;
            o_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            o_wb_ack <= w_ack_nxt;
            o_wb_err <= w_err_nxt;
            o_wb_dat <= w_dat_nxt;
            o_busy   <= w_busy_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_cap && !i_reset) begin
            r_adr <= i_wb_adr;
            r_dat <= i_wb_dat;
            r_sel <= i_wb_sel;
            r_wen <= i_wb_wen;
        end
    end

    // Write commits with the termination so reset in RESP discards it.
    always_ff @(posedge i_clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sel[b]) mem[w_idx][8*b +: 8] <= r_dat[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// Scoreboard bench for zap_wb_mem_responder.
// Three instances cover 0, 1 and 3 wait states.
module tb_zap_wb_mem_responder;

    localparam int NI = 3;
    localparam int WS [NI] = '{0, 1, 3};

    typedef struct {
        int          k;
        bit          err;
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [NI];
    logic        stb [NI];
    logic        wen [NI];
    logic [3:0]  sel [NI];
    logic [31:0] adr [NI];
    logic [31:0] wd  [NI];
    logic [31:0] rd  [NI];
    logic        ack [NI];
    logic        err [NI];
    logic        busy[NI];

    int   cnum   = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cnum <= cnum + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        zap_wb_mem_responder #(
            .DEPTH      (1024),
            .WAIT_STATES(WS[g]),
            .BASE_ADDR  (32'h0)
        ) dut (
            .i_clk   (clk),
            .i_reset (rst),
            .i_wb_cyc(cyc[g]),
            .i_wb_stb(stb[g]),
            .i_wb_wen(wen[g]),
            .i_wb_sel(sel[g]),
            .i_wb_adr(adr[g]),
            .i_wb_dat(wd[g]),
            .o_wb_dat(rd[g]),
            .o_wb_ack(ack[g]),
            .o_wb_err(err[g]),
            .o_busy  (busy[g])
        );
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per termination, checks cycle too.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (ack[k] === 1'b1 || err[k] === 1'b1) begin
                n_chk++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_term dut%0d ack=%b err=%b cyc=%0d",
                             k, ack[k], err[k], cnum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.k != k || ack[k] !== !e.err || err[k] !== e.err ||
                        rd[k] !== e.dat || e.cyc != cnum) begin
                        n_fail++;
                        $display("FAIL term dut%0d: got ack=%b err=%b dat=%h cyc=%0d expected dut%0d err=%b dat=%h cyc=%0d",
                                 k, ack[k], err[k], rd[k], cnum, e.k, e.err, e.dat, e.cyc);
                    end
                end
            end else if (!rst) begin
                n_chk++;
                if (rd[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL idle_dat dut%0d: got %h expected 0", k, rd[k]);
                end
            end
        end
    end

    task automatic drive(int k, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
        cyc[k] = 1'b1;
        stb[k] = 1'b1;
        wen[k] = w;
        sel[k] = s;
        adr[k] = a;
        wd[k]  = d;
    endtask

    task automatic release_bus(int k);
        cyc[k] = 1'b0;
        stb[k] = 1'b0;
    endtask

    task automatic xfer(int k, bit w, logic [3:0] s, logic [31:0] a,
                        logic [31:0] d, bit eerr, logic [31:0] edat);
        bit done;
        @(posedge clk); #1;
        drive(k, w, s, a, d);
        sb.push_back('{k, eerr, edat, cnum + 2 + WS[k]});
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk); #1;
            if (ack[k] || err[k]) done = 1'b1;
        end
        release_bus(k);
        chk($sformatf("term_seen dut%0d adr %h", k, a), 32'(done), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            release_bus(k);
            wen[k] = 1'b0;
            sel[k] = 4'h0;
            adr[k] = 32'h0;
            wd[k]  = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_ack%0d", k),  32'(ack[k]),  32'd0);
            chk($sformatf("rst_err%0d", k),  32'(err[k]),  32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_dat%0d", k),  rd[k],        32'h0);
        end
        rst = 1'b0;

        // One wait state: basic read/write, byte lanes, range checks.
        xfer(1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, 32'h0);
        xfer(1, 0, 4'h0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        xfer(1, 1, 4'hF, 32'h8, 32'h1122_3344, 0, 32'h0);
        xfer(1, 1, 4'b0101, 32'h8, 32'hAABB_CCDD, 0, 32'h0);
        xfer(1, 0, 4'h0, 32'h8, 32'h0, 0, 32'h11BB_33DD);
        xfer(1, 1, 4'b0000, 32'h8, 32'hFFFF_FFFF, 0, 32'h0);
        xfer(1, 0, 4'h3, 32'hB, 32'h0, 0, 32'h11BB_33DD);
        xfer(1, 1, 4'hF, 32'h0, 32'h0BAD_F00D, 0, 32'h0);
        xfer(1, 0, 4'hF, 32'h1000, 32'h0, 1, 32'h0);
        xfer(1, 1, 4'hF, 32'h1000, 32'h5555_5555, 1, 32'h0);
        xfer(1, 1, 4'hF, 32'hFFFF_FFFC, 32'h6666_6666, 1, 32'h0);
        xfer(1, 0, 4'hF, 32'h0, 32'h0, 0, 32'h0BAD_F00D);
        xfer(1, 1, 4'hF, 32'hFFC, 32'hCAFE_F00D, 0, 32'h0);
        xfer(1, 0, 4'hF, 32'hFFC, 32'h0, 0, 32'hCAFE_F00D);
        xfer(1, 0, 4'hF, 32'h0, 32'h0, 0, 32'h0BAD_F00D);

        // Three wait states: abort via cyc drop in second WAIT cycle.
        xfer(2, 1, 4'hF, 32'h20, 32'h1234_5678, 0, 32'h0);
        @(posedge clk); #1;
        drive(2, 1, 4'hF, 32'h20, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("abort_busy_wait1", 32'(busy[2]), 32'd1);
        @(posedge clk); #1;
        release_bus(2);
        @(posedge clk); #1;
        chk("abort_busy_after", 32'(busy[2]), 32'd0);
        repeat (6) @(posedge clk);
        xfer(2, 0, 4'hF, 32'h20, 32'h0, 0, 32'h1234_5678);

        // Reset during WAIT of a write.
        @(posedge clk); #1;
        drive(2, 1, 4'hF, 32'h20, 32'h0000_0000);
        @(posedge clk); #1;
        chk("rstw_busy", 32'(busy[2]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        release_bus(2);
        chk("rstw_ack",  32'(ack[2]),  32'd0);
        chk("rstw_err",  32'(err[2]),  32'd0);
        chk("rstw_busy0", 32'(busy[2]), 32'd0);
        chk("rstw_dat",  rd[2],        32'h0);
        repeat (6) @(posedge clk);
        xfer(2, 0, 4'hF, 32'h20, 32'h0, 0, 32'h1234_5678);

        // Zero wait states: back-to-back reads with stb held.
        xfer(0, 1, 4'hF, 32'h10, 32'hA5A5_A5A5, 0, 32'h0);
        xfer(0, 1, 4'hF, 32'h14, 32'h5A5A_5A5A, 0, 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 4'hF, 32'h10, 32'h0);
        sb.push_back('{0, 1'b0, 32'hA5A5_A5A5, cnum + 2});
        @(posedge clk); #1;
        chk("b2b_busy", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        chk("b2b_ack1", 32'(ack[0]), 32'd1);
        adr[0] = 32'h14;
        sb.push_back('{0, 1'b0, 32'h5A5A_5A5A, cnum + 2});
        @(posedge clk); #1;
        chk("b2b_gap", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        chk("b2b_ack2", 32'(ack[0]), 32'd1);
        release_bus(0);
        repeat (6) @(posedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
